npc_sram_responder: RTL and testbench
=====================================

Name: npc_sram_responder

Overview:
- Memory-side responder for the NPC LSU data-memory valid/ready interface.
- Accepts one read or write request at a time and serves it from an internal word array after a configurable latency.
- Returns completion as a one-cycle ready pulse with registered read data.
- Replaces the zero-wait SRAM stub so LSU/EXU handshake stalls get exercised.

Parameters:
- BASE_ADDR, 32'h80000000, byte address mapped to word 0.
- DEPTH_WORDS, 16384, number of 32-bit words; power of two.
- LATENCY, 1, fixed wait cycles between accept and response (0..15).
- INIT_FILE, "", hex image loaded by $readmemh at time 0 when non-empty.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- valid  in  1  request valid from LSU.
- addr  in  32  byte address; bits [1:0] ignored.
- wen  in  1  1 = write, 0 = read.
- wdata  in  32  write data.
- wmask  in  4  byte enables; bit i writes byte i.
- ready  out  1  one-cycle completion pulse.
- rdata  out  32  read data; valid in the ready cycle.
- err  out  1  out-of-range flag; valid in the ready cycle.

Behaviour:
- Reset values: ready=0, rdata=0, err=0, state=IDLE, counter=0. Memory contents are not cleared.
- FSM states and transitions:
  - IDLE: when valid=1 is sampled, latch addr/wen/wdata/wmask and load the counter with the effective latency L. Go to RESP if L=0, else go to WAIT.
  - WAIT: decrement the counter each cycle. When the counter reaches 1, go to RESP.
  - RESP: ready=1 for exactly this one cycle, then return to IDLE.
- Latency: with valid sampled at edge N, ready is high in the cycle following edge N+L. A request is never accepted while in RESP or WAIT, so the minimum request spacing is L+2 cycles.
- Address decode: index = (addr - BASE_ADDR) >> 2. The request is in range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS; compare in 33-bit arithmetic.
- Read: rdata is loaded with mem[index] on the edge entering RESP. rdata holds its value until the next read response.
- Write: committed on the edge entering RESP, bytes gated by wmask. wmask=0 completes normally with no change. During a write response rdata is unchanged.
- Out-of-range request: write dropped, rdata=0, err=1 in the ready cycle. err=0 in all other cycles.
- Initiator contract: hold valid and the request fields until ready. If valid drops mid-transaction, the latched request still completes, including the write commit, and ready still pulses.
- Reset mid-operation: FSM returns to IDLE immediately. A write whose commit edge has not yet occurred is discarded. No ready pulse is produced.
- Request fields are sampled only in IDLE. Changes during WAIT/RESP have no effect.

Optional Feature:
- Macro: NPC_SRAM_RAND_DELAY_EN.
- Defined:
  - An 8-bit LFSR (taps 8,6,5,4) is seeded to 8'hA5 on reset and advances every cycle.
  - Effective latency at accept is L = LATENCY + lfsr[1:0].
- Undefined: L = LATENCY; no LFSR logic is present.

Test Plan:
- LATENCY=1: write 32'hDEADBEEF, mask 4'hF, to 32'h80000010, then read it back. Each ready comes 2 cycles after accept; the read returns rdata=32'hDEADBEEF, err=0.
- Partial write: after the above, write 32'h00AA0000 with mask 4'b0100, then read. Read returns rdata=32'hDEAABEEF.
- Out of range: read 32'h7FFFFFFC, then write 32'h80010000 with DEPTH_WORDS=16384. Each gets ready with err=1; the read returns rdata=0; a later read of word 0 is unchanged.
- LATENCY=0, back-to-back: valid held high for two reads of 0x80000000 and 0x80000004. Ready arrives 1 cycle after each accept; accepts are spaced 2 cycles apart; ready is never high on two consecutive cycles.
- Reset mid-op: LATENCY=3 write of 32'h12345678 to 0x80000020, rst asserted 1 cycle after accept. No ready pulse; a later read of 0x80000020 returns the old value.
- With NPC_SRAM_RAND_DELAY_EN: 100 random requests. Every accept-to-ready distance is in LATENCY+1..LATENCY+4; the data matches a scoreboard.

Source files
------------

// File: rtl/npc_sram_responder.sv
// Purpose : Memory-side responder for the NPC LSU data-memory valid/ready port.
//           It serves one read or write at a time from an internal word array.
// Latency : A request sampled at edge N gives a one-cycle ready in the cycle after edge N+L.
//           L = LATENCY, plus lfsr[1:0] when NPC_SRAM_RAND_DELAY_EN is defined.
// Backpr. : Only one request is outstanding. valid is ignored in WAIT and RESP,
//           so the initiator holds its request until ready.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   valid         request valid; addr/wen/wdata/wmask are sampled only in IDLE
//   addr          byte address; bits [1:0] are ignored
//   wen           1 = write, 0 = read
//   wdata, wmask  write data and byte enables (bit i enables byte i)
//   ready         one-cycle completion pulse
//   rdata, err    read data and out-of-range flag; both are valid in the ready cycle
//
// Optional feature: define NPC_SRAM_RAND_DELAY_EN to add a pseudo-random
// 0..3 cycle delay per request. The delay comes from an 8-bit LFSR.

module npc_sram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter int unsigned LATENCY     = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [31:0] addr,
    input  logic        wen,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] BASE_EXT = {1'b0, BASE_ADDR};
    localparam logic [32:0] LIMIT    = BASE_EXT + (33'(DEPTH_WORDS) << 2);
    localparam logic [4:0]  LAT_BASE = 5'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [4:0]  lat_eff;

    logic [31:0] mem [DEPTH_WORDS];

`ifdef NPC_SRAM_RAND_DELAY_EN
    // Fibonacci LFSR for x^8 + x^6 + x^5 + x^4 + 1. It advances every cycle,
    // so the extra delay depends on when the request arrives.
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lat_eff = LAT_BASE + {3'b000, lfsr_q[1:0]};
`else
    assign lat_eff = LAT_BASE;
`endif

    // The memory operation happens on the edge that enters RESP. With L=0
    // that is also the accept edge, so the request has not been latched yet.
    // In IDLE the live port fields are used; otherwise the latched copy is used.
    logic        in_idle;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;

    assign in_idle   = (state_q == IDLE);
    assign req_addr  = in_idle ? addr  : addr_q;
    assign req_wen   = in_idle ? wen   : wen_q;
    assign req_wdata = in_idle ? wdata : wdata_q;
    assign req_wmask = in_idle ? wmask : wmask_q;

    // The range check uses 33-bit arithmetic so a window that ends at 2^32 does not wrap.
    logic [32:0]      addr_ext;
    logic [32:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             unused_offset_bits;

    assign addr_ext           = {1'b0, req_addr};
    assign offset             = addr_ext - BASE_EXT;
    assign in_range           = (addr_ext >= BASE_EXT) && (addr_ext < LIMIT);
    assign idx                = offset[IDX_W+1:2];
    assign unused_offset_bits = ^{offset[32:IDX_W+2], offset[1:0]};

    // FSM: next state, counter and request latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;

        unique case (state_q)
            IDLE: begin
                if (valid) begin
                    addr_d  = addr;
                    wen_d   = wen;
                    wdata_d = wdata;
                    wmask_d = wmask;
                    cnt_d   = lat_eff;
                    state_d = (lat_eff == 5'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q <= 5'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    logic enter_resp;
    logic mem_we;

    assign enter_resp = (state_d == RESP) && (state_q != RESP);
    // With a synchronous reset, reset on the commit edge must still suppress the write.
    assign mem_we     = enter_resp && in_range && req_wen && !rst;

    // Response datapath. rdata keeps its value across write responses.
    always_comb begin
        rdata_d = rdata_q;
        err_d   = 1'b0;
        if (enter_resp) begin
            if (!in_range) begin
                rdata_d = 32'h0;
                err_d   = 1'b1;
            end else if (!req_wen) begin
                rdata_d = mem[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            addr_q  <= 32'h0;
            wen_q   <= 1'b0;
            wdata_q <= 32'h0;
            wmask_q <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory contents are deliberately not affected by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (req_wmask[b]) begin
                    mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    assign ready = (state_q == RESP);
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_npc_sram_responder.sv
module tb_npc_sram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Three instances: index 0 LATENCY=1, index 1 LATENCY=0, index 2 LATENCY=3.
    logic        rst   [3];
    logic        valid [3];
    logic [31:0] addr  [3];
    logic        wen   [3];
    logic [31:0] wdata [3];
    logic [3:0]  wmask [3];
    logic        ready [3];
    logic [31:0] rdata [3];
    logic        err   [3];

    int checks = 0;
    int errors = 0;

    npc_sram_responder #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst[0]), .valid(valid[0]), .addr(addr[0]), .wen(wen[0]),
        .wdata(wdata[0]), .wmask(wmask[0]), .ready(ready[0]), .rdata(rdata[0]), .err(err[0])
    );

    npc_sram_responder #(.LATENCY(0)) u_l0 (
        .clk(clk), .rst(rst[1]), .valid(valid[1]), .addr(addr[1]), .wen(wen[1]),
        .wdata(wdata[1]), .wmask(wmask[1]), .ready(ready[1]), .rdata(rdata[1]), .err(err[1])
    );

    npc_sram_responder #(.LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst[2]), .valid(valid[2]), .addr(addr[2]), .wen(wen[2]),
        .wdata(wdata[2]), .wmask(wmask[2]), .ready(ready[2]), .rdata(rdata[2]), .err(err[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Count edges until ready is seen #1 after an edge. Bounded wait.
    task automatic wait_ready(input int d, input string tag, output int lat);
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (ready[d]) return;
        end
        check($sformatf("%s_timeout", tag), 32'(ready[d]), 32'd1);
    endtask

    task automatic check_lat(input string tag, input int lat, input int exp_lat);
`ifdef NPC_SRAM_RAND_DELAY_EN
        check($sformatf("%s_lat_range", tag), 32'((lat >= exp_lat) && (lat <= exp_lat + 3)), 32'd1);
`else
        check($sformatf("%s_lat", tag), 32'(lat), 32'(exp_lat));
`endif
    endtask

    // One complete transaction. exp_lat is edges from drive to visible ready (L+1).
    task automatic req(input string tag, input int d, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] m, input int exp_lat,
                       input logic exp_err, input logic chk_data, input logic [31:0] exp_data);
        int lat;
        valid[d] = 1'b1;
        wen[d]   = we;
        addr[d]  = a;
        wdata[d] = wd;
        wmask[d] = m;
        wait_ready(d, tag, lat);
        valid[d] = 1'b0;
        check_lat(tag, lat, exp_lat);
        check($sformatf("%s_err", tag), 32'(err[d]), 32'(exp_err));
        if (chk_data) check($sformatf("%s_rdata", tag), rdata[d], exp_data);
        @(posedge clk);
        #1;
        check($sformatf("%s_ready_drop", tag), 32'(ready[d]), 32'd0);
        check($sformatf("%s_err_drop", tag), 32'(err[d]), 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] sb [16];
        logic [31:0] last_rd;

        for (int i = 0; i < 3; i++) begin
            rst[i]   = 1'b1;
            valid[i] = 1'b0;
            addr[i]  = 32'h0;
            wen[i]   = 1'b0;
            wdata[i] = 32'h0;
            wmask[i] = 4'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_ready%0d", i), 32'(ready[i]), 32'd0);
            check($sformatf("reset_rdata%0d", i), rdata[i], 32'd0);
            check($sformatf("reset_err%0d", i), 32'(err[i]), 32'd0);
        end
        @(posedge clk);
        #1;

        // LATENCY=1: full write and read, partial writes, wmask=0, out of range.
        req("w_full",  0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF,    2, 1'b0, 1'b0, 32'h0);
        req("r_full",  0, 1'b0, 32'h8000_0010, 32'h0,         4'h0,    2, 1'b0, 1'b1, 32'hDEAD_BEEF);
        req("w_part",  0, 1'b1, 32'h8000_0010, 32'h00AA_0000, 4'b0100, 2, 1'b0, 1'b1, 32'hDEAD_BEEF);
        req("r_part",  0, 1'b0, 32'h8000_0010, 32'h0,         4'h0,    2, 1'b0, 1'b1, 32'hDEAA_BEEF);
        req("w_mask0", 0, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0,    2, 1'b0, 1'b1, 32'hDEAA_BEEF);
        req("r_mask0", 0, 1'b0, 32'h8000_0010, 32'h0,         4'h0,    2, 1'b0, 1'b1, 32'hDEAA_BEEF);
        req("w_word0", 0, 1'b1, 32'h8000_0000, 32'h1122_3344, 4'hF,    2, 1'b0, 1'b0, 32'h0);
        req("r_oor_lo", 0, 1'b0, 32'h7FFF_FFFC, 32'h0,        4'h0,    2, 1'b1, 1'b1, 32'h0);
        // One past the last word; it would alias to word 0 if the write were not dropped.
        req("w_oor_hi", 0, 1'b1, 32'h8001_0000, 32'hCAFE_BABE, 4'hF,   2, 1'b1, 1'b1, 32'h0);
        req("r_word0", 0, 1'b0, 32'h8000_0000, 32'h0,         4'h0,    2, 1'b0, 1'b1, 32'h1122_3344);
        req("w_last",  0, 1'b1, 32'h8000_FFFC, 32'h0F0F_0F0F, 4'hF,    2, 1'b0, 1'b0, 32'h0);
        req("r_last",  0, 1'b0, 32'h8000_FFFF, 32'h0,         4'h0,    2, 1'b0, 1'b1, 32'h0F0F_0F0F);

        // LATENCY=0: back-to-back reads with valid held high.
        req("l0_w0", 1, 1'b1, 32'h8000_0000, 32'hA5A5_A5A5, 4'hF, 1, 1'b0, 1'b0, 32'h0);
        req("l0_w1", 1, 1'b1, 32'h8000_0004, 32'h5A5A_5A5A, 4'hF, 1, 1'b0, 1'b0, 32'h0);
        valid[1] = 1'b1;
        wen[1]   = 1'b0;
        addr[1]  = 32'h8000_0000;
        wait_ready(1, "b2b_a", lat);
        check_lat("b2b_a", lat, 1);
        check("b2b_a_rdata", rdata[1], 32'hA5A5_A5A5);
        addr[1] = 32'h8000_0004;
        @(posedge clk);
        #1;
        check("b2b_gap_ready", 32'(ready[1]), 32'd0);
        wait_ready(1, "b2b_b", lat);
        check_lat("b2b_b", lat, 1);
        check("b2b_b_rdata", rdata[1], 32'h5A5A_5A5A);
        valid[1] = 1'b0;
        @(posedge clk);
        #1;

        // LATENCY=3: reset one cycle after accept discards the pending write.
        req("l3_init", 2, 1'b1, 32'h8000_0020, 32'h0BAD_F00D, 4'hF, 4, 1'b0, 1'b0, 32'h0);
        valid[2] = 1'b1;
        wen[2]   = 1'b1;
        addr[2]  = 32'h8000_0020;
        wdata[2] = 32'h1234_5678;
        wmask[2] = 4'hF;
        @(posedge clk);
        #1;
        rst[2]   = 1'b1;
        valid[2] = 1'b0;
        @(posedge clk);
        #1;
        rst[2] = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (ready[2]) seen++;
            @(posedge clk);
            #1;
        end
        check("rst_no_ready", 32'(seen), 32'd0);
        req("l3_rd_old", 2, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 4, 1'b0, 1'b1, 32'h0BAD_F00D);

`ifdef NPC_SRAM_RAND_DELAY_EN
        // Random traffic over 16 words, checked against a scoreboard.
        last_rd = 32'h0F0F_0F0F;
        for (int k = 0; k < 16; k++) begin
            sb[k] = $urandom;
            req("rnd_init", 0, 1'b1, 32'h8000_0000 + 32'(4 * k), sb[k], 4'hF, 2, 1'b0, 1'b1, last_rd);
        end
        for (int n = 0; n < 100; n++) begin
            int          w;
            logic        we;
            logic [31:0] wd;
            logic [3:0]  m;
            w  = int'($urandom_range(0, 15));
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            m  = 4'($urandom_range(0, 15));
            if (we) begin
                req("rnd_w", 0, 1'b1, 32'h8000_0000 + 32'(4 * w), wd, m, 2, 1'b0, 1'b1, last_rd);
                for (int b = 0; b < 4; b++) begin
                    if (m[b]) sb[w][8*b +: 8] = wd[8*b +: 8];
                end
            end else begin
                req("rnd_r", 0, 1'b0, 32'h8000_0000 + 32'(4 * w), 32'h0, 4'h0, 2, 1'b0, 1'b1, sb[w]);
                last_rd = sb[w];
            end
        end
`else
        last_rd = 32'h0;
        sb[0]   = 32'h0;
        if (last_rd != sb[0]) $display("note: unused scoreboard");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
